// File: rtl/inference_monitor_if.sv
// Register-file writeback and retire taps snooped by the run monitor.
interface inference_monitor_if #(
  parameter int DWidth = 32
);
  logic              wb_en_i;
  logic [4:0]        wb_addr_i;
  logic [DWidth-1:0] wb_data_i;
  logic              retire_i;

  modport master (output wb_en_i, wb_addr_i, wb_data_i, retire_i);
  modport slave  (input  wb_en_i, wb_addr_i, wb_data_i, retire_i);
endinterface

// File: rtl/inference_monitor.sv
// Run monitor: snoops writebacks for test index, correct count and exit code,
// keeps cycle/instret/lap counters and a watchdog, then divides out the accuracy.
module inference_monitor #(
  parameter int          DWidth        = 32,
  parameter int          NumOfTest     = 10,
  parameter int          ExitReg       = 25,
  parameter int          ExitCode      = 99999,
  parameter int          IdxReg        = 26,
  parameter int          CorrReg       = 27,
  parameter logic [31:0] TimeoutCycles = 32'h0200_0000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  inference_monitor_if.slave  wb,
  output logic                done_o,
  output logic                timeout_o,
  output logic [DWidth-1:0]   test_idx_o,
  output logic [DWidth-1:0]   correct_cnt_o,
  output logic [6:0]          accuracy_o,
  output logic                accuracy_valid_o,
  output logic [63:0]         cycle_cnt_o,
  output logic [63:0]         instret_cnt_o,
  output logic [DWidth-1:0]   lap_cycles_o,
  output logic                lap_valid_o
);

  localparam int DivW = $clog2(100 * NumOfTest + 1);
  localparam int RemW = DivW + 1;
  localparam int CntW = $clog2(DivW) + 1;

  typedef enum logic [1:0] {RUN, DIV, DONE, TIMEOUT} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [63:0]       r_cycleCnt;
  logic [63:0]       r_instretCnt;
  logic [DWidth-1:0] r_testIdx;
  logic [DWidth-1:0] r_corrCnt;
  logic [DWidth-1:0] r_lapCnt;
  logic [DWidth-1:0] r_lapCycles;
  logic              r_lapValid;
  logic [DivW-1:0]   r_quo;
  logic [RemW-1:0]   r_rem;
  logic [CntW-1:0]   r_bitCnt;

  logic              w_snoop;
  logic              w_exitWr;
  logic              w_idxWr;
  logic              w_corrWr;
  logic              w_watchdog;
  logic [DWidth-1:0] w_corrMin;
  logic [DivW-1:0]   w_dividend;
  logic [RemW-1:0]   w_remShift;
  logic [RemW-1:0]   w_remSub;
  logic              w_geq;
  logic [6:0]        w_accSat;

  assign w_snoop    = (r_state == RUN) && wb.wb_en_i && (wb.wb_addr_i != 5'd0);
  assign w_exitWr   = w_snoop && (wb.wb_addr_i == 5'(ExitReg)) && (wb.wb_data_i == DWidth'(ExitCode));
  assign w_idxWr    = w_snoop && (wb.wb_addr_i == 5'(IdxReg));
  assign w_corrWr   = w_snoop && (wb.wb_addr_i == 5'(CorrReg));
  assign w_watchdog = (TimeoutCycles != 32'd0) && (r_cycleCnt == {32'd0, TimeoutCycles} - 64'd1);

  // The exit write is a separate writeback, so the registered count feeds the divider.
  assign w_corrMin  = (r_corrCnt > DWidth'(NumOfTest)) ? DWidth'(NumOfTest) : r_corrCnt;
  assign w_dividend = DivW'(w_corrMin) * DivW'(100);

  // Restoring divider: dividend shifts out of r_quo while quotient bits shift in.
  assign w_remShift = {r_rem[RemW-2:0], r_quo[DivW-1]};
  assign w_geq      = w_remShift >= RemW'(NumOfTest);
  assign w_remSub   = w_remShift - RemW'(NumOfTest);
  assign w_accSat   = (r_quo > DivW'(100)) ? 7'd100 : r_quo[6:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= RUN;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      RUN:     if (w_exitWr) w_nextState = DIV;
               else if (w_watchdog) w_nextState = TIMEOUT;
      DIV:     if (r_bitCnt == CntW'(DivW - 1)) w_nextState = DONE;
      default: w_nextState = r_state;
    endcase
  end

  always_comb begin
    done_o           = (r_state == DONE) || (r_state == TIMEOUT);
    timeout_o        = (r_state == TIMEOUT);
    accuracy_valid_o = (r_state == DONE);
    accuracy_o       = (r_state == DONE) ? w_accSat : 7'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cycleCnt   <= '0;
      r_instretCnt <= '0;
      r_testIdx    <= '0;
      r_corrCnt    <= '0;
      r_lapCnt     <= '0;
      r_lapCycles  <= '0;
      r_lapValid   <= 1'b0;
      r_quo        <= '0;
      r_rem        <= '0;
      r_bitCnt     <= '0;
    end else begin
      r_lapValid <= 1'b0;
      if (r_state == RUN) begin
        r_cycleCnt <= r_cycleCnt + 64'd1;
        if (wb.retire_i) r_instretCnt <= r_instretCnt + 64'd1;
        if (r_lapCnt != '1) r_lapCnt <= r_lapCnt + 1'b1;
        if (w_idxWr) begin
          r_testIdx <= wb.wb_data_i;
          if (wb.wb_data_i != r_testIdx) begin
            r_lapCycles <= (r_lapCnt == '1) ? '1 : r_lapCnt + 1'b1;
            r_lapValid  <= 1'b1;
            r_lapCnt    <= '0;
          end
        end
        if (w_corrWr) r_corrCnt <= wb.wb_data_i;
        if (w_exitWr) begin
          r_quo    <= w_dividend;
          r_rem    <= '0;
          r_bitCnt <= '0;
        end
      end else if (r_state == DIV) begin
        r_rem    <= w_geq ? w_remSub : w_remShift;
        r_quo    <= {r_quo[DivW-2:0], w_geq};
        r_bitCnt <= r_bitCnt + 1'b1;
      end
    end
  end

  assign test_idx_o    = r_testIdx;
  assign correct_cnt_o = r_corrCnt;
  assign cycle_cnt_o   = r_cycleCnt;
  assign instret_cnt_o = r_instretCnt;
  assign lap_cycles_o  = r_lapCycles;
  assign lap_valid_o   = r_lapValid;

endmodule

// File: tb/tb_inference_monitor.sv
// Bench for inference_monitor: directed scenarios plus random runs against a
// cycle-level behavioural model of the run monitor.
module tb_inference_monitor;

  localparam int NumOfTest = 10;
  localparam int DivW      = $clog2(100 * NumOfTest + 1);
  localparam int ExitCode  = 99999;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  inference_monitor_if #(.DWidth(32)) bus ();

  logic        done, timeout, accValid, lapValid;
  logic [31:0] testIdx, correctCnt, lapCycles;
  logic [6:0]  accuracy;
  logic [63:0] cycleCnt, instretCnt;

  logic        toDone, toTimeout, toAccValid, toLapValid;
  logic [31:0] toTestIdx, toCorrectCnt, toLapCycles;
  logic [6:0]  toAccuracy;
  logic [63:0] toCycleCnt, toInstretCnt;

  inference_monitor #(.DWidth(32), .NumOfTest(NumOfTest), .TimeoutCycles(32'd0)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .wb(bus.slave),
    .done_o(done), .timeout_o(timeout), .test_idx_o(testIdx), .correct_cnt_o(correctCnt),
    .accuracy_o(accuracy), .accuracy_valid_o(accValid), .cycle_cnt_o(cycleCnt),
    .instret_cnt_o(instretCnt), .lap_cycles_o(lapCycles), .lap_valid_o(lapValid)
  );

  inference_monitor #(.DWidth(32), .NumOfTest(NumOfTest), .TimeoutCycles(32'd64)) u_dutTo (
    .clk_i(clk_i), .rst_i(rst_i), .wb(bus.slave),
    .done_o(toDone), .timeout_o(toTimeout), .test_idx_o(toTestIdx), .correct_cnt_o(toCorrectCnt),
    .accuracy_o(toAccuracy), .accuracy_valid_o(toAccValid), .cycle_cnt_o(toCycleCnt),
    .instret_cnt_o(toInstretCnt), .lap_cycles_o(toLapCycles), .lap_valid_o(toLapValid)
  );

  int checkCount = 0;
  int errorCount = 0;

  // Reference model of the main (watchdog-disabled) monitor.
  longint      mCycle, mInstret, mLastClear;
  logic [31:0] mIdx, mCorr, mLapCycles;
  bit          mLapValid, mRun, mDone;
  int          mDivLeft, mAcc;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int expAccuracy(input logic [31:0] corr);
    longint c;
    c = (corr > 32'(NumOfTest)) ? longint'(NumOfTest) : longint'(corr);
    return int'((c * 100) / NumOfTest);
  endfunction

  task automatic checkMain();
    checkOutput("cycle_cnt", cycleCnt, 64'(mCycle));
    checkOutput("instret_cnt", instretCnt, 64'(mInstret));
    checkOutput("test_idx", {32'd0, testIdx}, {32'd0, mIdx});
    checkOutput("correct_cnt", {32'd0, correctCnt}, {32'd0, mCorr});
    checkOutput("lap_valid", {63'd0, lapValid}, {63'd0, mLapValid});
    checkOutput("lap_cycles", {32'd0, lapCycles}, {32'd0, mLapCycles});
    checkOutput("done", {63'd0, done}, {63'd0, mDone});
    checkOutput("accuracy_valid", {63'd0, accValid}, {63'd0, mDone});
    checkOutput("accuracy", {57'd0, accuracy}, mDone ? 64'(mAcc) : 64'd0);
    checkOutput("timeout", {63'd0, timeout}, 64'd0);
  endtask

  task automatic resetDuts();
    bus.wb_en_i = 1'b0; bus.wb_addr_i = 5'd0; bus.wb_data_i = 32'd0; bus.retire_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    mCycle = 0; mInstret = 0; mLastClear = -1;
    mIdx = 0; mCorr = 0; mLapCycles = 0; mLapValid = 0;
    mRun = 1; mDone = 0; mDivLeft = 0; mAcc = 0;
    checkMain();
    checkOutput("to_reset_done", {63'd0, toDone}, 64'd0);
    checkOutput("to_reset_timeout", {63'd0, toTimeout}, 64'd0);
    checkOutput("to_reset_cycle", toCycleCnt, 64'd0);
    checkOutput("to_reset_lap", {31'd0, toLapValid, toLapCycles}, 64'd0);
  endtask

  // Drives one cycle of writeback/retire and advances the model by one edge.
  task automatic applyStimulus(input bit en, input logic [4:0] addr, input logic [31:0] data, input bit ret);
    bit snoop;
    longint lap;
    bus.wb_en_i = en; bus.wb_addr_i = addr; bus.wb_data_i = data; bus.retire_i = ret;
    mLapValid = 0;
    if (mRun) begin
      snoop = en && (addr != 5'd0);
      if (snoop && addr == 5'd26 && data != mIdx) begin
        lap = mCycle - mLastClear;
        mLapCycles = (lap > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(lap);
        mLapValid  = 1;
        mLastClear = mCycle;
      end
      if (snoop && addr == 5'd26) mIdx = data;
      if (snoop && addr == 5'd27) mCorr = data;
      if (ret) mInstret++;
      if (snoop && addr == 5'd25 && data == 32'(ExitCode)) begin
        mRun = 0; mDivLeft = DivW; mAcc = expAccuracy(mCorr);
      end
      mCycle++;
    end else if (mDivLeft > 0) begin
      mDivLeft--;
      if (mDivLeft == 0) mDone = 1;
    end
    @(posedge clk_i); #1;
    bus.wb_en_i = 1'b0;
    checkMain();
  endtask

  task automatic idle(input int n, input bit ret);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'd0, ret);
  endtask

  task automatic writeExit(input bit ret);
    applyStimulus(1'b1, 5'd25, 32'(ExitCode), ret);
  endtask

  initial begin
    // Directed: 20 retiring cycles, then exit, then the divide latency.
    resetDuts();
    idle(20, 1'b1);
    writeExit(1'b1);
    checkOutput("exit_cycle21", cycleCnt, 64'd21);
    checkOutput("exit_instret21", instretCnt, 64'd21);
    idle(DivW + 3, 1'b1);
    checkOutput("exit_done", {63'd0, done}, 64'd1);

    // Directed accuracies: in-range and saturating counts.
    resetDuts();
    applyStimulus(1'b1, 5'd27, 32'd7, 1'b1);
    writeExit(1'b0);
    idle(DivW, 1'b0);
    checkOutput("acc70", {57'd0, accuracy}, 64'd70);
    resetDuts();
    applyStimulus(1'b1, 5'd27, 32'd13, 1'b1);
    idle(3, 1'b0);
    writeExit(1'b0);
    idle(DivW, 1'b0);
    checkOutput("acc100", {57'd0, accuracy}, 64'd100);

    // Lap sequence with a repeated index value.
    resetDuts();
    idle(10, 1'b0);
    applyStimulus(1'b1, 5'd26, 32'd1, 1'b0);
    idle(99, 1'b0);
    applyStimulus(1'b1, 5'd26, 32'd2, 1'b0);
    idle(49, 1'b0);
    applyStimulus(1'b1, 5'd26, 32'd2, 1'b0);
    idle(29, 1'b0);
    applyStimulus(1'b1, 5'd26, 32'd3, 1'b0);
    checkOutput("lap_2_to_3", {32'd0, lapCycles}, 64'd80);
    idle(2, 1'b0);

    // Watchdog expiry on the 64-cycle instance; a later exit is ignored.
    resetDuts();
    idle(63, 1'b1);
    checkOutput("to_not_yet", {63'd0, toTimeout}, 64'd0);
    idle(1, 1'b1);
    checkOutput("to_timeout", {63'd0, toTimeout}, 64'd1);
    checkOutput("to_done", {63'd0, toDone}, 64'd1);
    checkOutput("to_accvalid", {63'd0, toAccValid}, 64'd0);
    checkOutput("to_cycle64", toCycleCnt, 64'd64);
    writeExit(1'b1);
    idle(DivW + 2, 1'b1);
    checkOutput("to_stays_timeout", {63'd0, toTimeout}, 64'd1);
    checkOutput("to_stays_accvalid", {63'd0, toAccValid}, 64'd0);
    checkOutput("to_frozen_cycle", toCycleCnt, 64'd64);
    checkOutput("to_frozen_instret", toInstretCnt, 64'd64);

    // Exit on the watchdog's last cycle beats the timeout.
    resetDuts();
    applyStimulus(1'b1, 5'd27, 32'd4, 1'b0);
    idle(62, 1'b0);
    writeExit(1'b0);
    checkOutput("race_timeout", {63'd0, toTimeout}, 64'd0);
    checkOutput("race_done_early", {63'd0, toDone}, 64'd0);
    idle(DivW, 1'b0);
    checkOutput("race_done", {63'd0, toDone}, 64'd1);
    checkOutput("race_accvalid", {63'd0, toAccValid}, 64'd1);
    checkOutput("race_acc", {57'd0, toAccuracy}, 64'(expAccuracy(32'd4)));

    // Reset in the middle of a divide, then a fresh run.
    resetDuts();
    applyStimulus(1'b1, 5'd27, 32'd5, 1'b1);
    writeExit(1'b1);
    idle(3, 1'b0);
    resetDuts();
    applyStimulus(1'b1, 5'd27, 32'd3, 1'b1);
    writeExit(1'b1);
    idle(DivW, 1'b0);
    checkOutput("acc30", {57'd0, accuracy}, 64'd30);

    // Random runs with mixed writebacks checked every cycle against the model.
    for (int run = 0; run < 8; run++) begin
      int n;
      resetDuts();
      n = $urandom_range(150, 20);
      for (int c = 0; c < n; c++) begin
        logic [4:0]  addr;
        logic [31:0] data;
        case ($urandom_range(4, 0))
          0: addr = 5'd0;
          1: addr = 5'd25;
          2: addr = 5'd26;
          3: addr = 5'd27;
          default: addr = 5'($urandom_range(31, 1));
        endcase
        case ($urandom_range(2, 0))
          0: data = 32'($urandom_range(3, 0));
          1: data = 32'($urandom_range(15, 0));
          default: data = $urandom;
        endcase
        if (data == 32'(ExitCode)) data = 32'd0;
        applyStimulus(1'($urandom_range(1, 0)), addr, data, 1'($urandom_range(1, 0)));
      end
      writeExit(1'($urandom_range(1, 0)));
      idle(DivW + 2, 1'($urandom_range(1, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
